// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird game controller.
//   game_state_t : top-level game flow states (encoding is visible on state_o)
//   bcd2_t       : two-digit packed BCD value {tens, ones}
//   lfsr_next    : one step of the 8-bit gap-selection LFSR
package flappy_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2,
        S_CLEAR = 2'd3
    } game_state_t;

    typedef logic [7:0] bcd2_t;

    localparam int unsigned ROWS      = 16;
    localparam int unsigned ROW_W     = $clog2(ROWS);
    localparam int unsigned GAP_ROWS  = 4;
    // 8 LFSR-selected gap positions, placed one row below centre of the field
    localparam int unsigned GAP_BASE  = (ROWS - GAP_ROWS - 8) / 2 + 1;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3)
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up-counter, saturating at 99.
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : return to 00 (wins over inc_i)
//   inc_i      : add one
//   value_o    : registered BCD count {tens, ones}
module bcd2_counter
    import flappy_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear_i,
    input  logic  inc_i,
    output bcd2_t value_o
);

    bcd2_t value_q;
    bcd2_t value_d;

    // Next count: ones digit rolls 9->0 with carry into tens
    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (inc_i && (value_q != 8'h99)) begin
            if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/flappy_game_sequencer.sv
// Game flow controller for the 16x16 LED Flappy Bird game.
// Runs IDLE -> PLAY -> OVER -> CLEAR, moves the bird, paces the pipe field
// and keeps the score and the high score.
//   clk, reset     : clock, synchronous active-high reset
//   flap_i         : debounced one-cycle button pulse
//   collide_i      : gameover from collision detector
//   add_point_i    : pipe-passed pulse from collision detector
//   state_o        : 0=IDLE 1=PLAY 2=OVER 3=CLEAR
//   playing_o      : high in PLAY (decoded from state)
//   bird_row_o     : bird row, 0 = top
//   pipe_shift_o   : pulse, shift pipe field one column
//   pipe_load_o    : pulse, inject pipe column; gap_row_o valid with it
//   gap_row_o      : top row of the 4-row gap
//   clear_field_o  : pulse, blank the pipe field
//   score_o        : BCD score
//   high_score_o   : BCD best score since reset
module flappy_game_sequencer
    import flappy_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 2500000,
    parameter int unsigned FALL_PERIOD  = 3,
    parameter int unsigned PIPE_PERIOD  = 2,
    parameter int unsigned PIPE_SPACING = 6,
    parameter int unsigned FLAP_ROWS    = 2,
    parameter int unsigned START_ROW    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flap_i,
    input  logic       collide_i,
    input  logic       add_point_i,
    output logic [1:0] state_o,
    output logic       playing_o,
    output logic [3:0] bird_row_o,
    output logic       pipe_shift_o,
    output logic       pipe_load_o,
    output logic [3:0] gap_row_o,
    output logic       clear_field_o,
    output logic [7:0] score_o,
    output logic [7:0] high_score_o
);

    localparam int unsigned TICK_W = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
    localparam int unsigned FALL_W = (FALL_PERIOD > 1)  ? $clog2(FALL_PERIOD)  : 1;
    localparam int unsigned PIPE_W = (PIPE_PERIOD > 1)  ? $clog2(PIPE_PERIOD)  : 1;
    localparam int unsigned SP_W   = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [FALL_W-1:0] FALL_LAST = FALL_W'(FALL_PERIOD - 1);
    localparam logic [PIPE_W-1:0] PIPE_LAST = PIPE_W'(PIPE_PERIOD - 1);
    localparam logic [SP_W-1:0]   SP_LAST   = SP_W'(PIPE_SPACING - 1);

    localparam logic [ROW_W-1:0] START_ROW_V = ROW_W'(START_ROW);
    localparam logic [ROW_W-1:0] FLAP_V      = ROW_W'(FLAP_ROWS);
    localparam logic [ROW_W-1:0] MAX_ROW     = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] GAP_BASE_V  = ROW_W'(GAP_BASE);

    game_state_t       state_q,      state_d;
    logic [TICK_W-1:0] tick_cnt_q,   tick_cnt_d;
    logic [FALL_W-1:0] fall_cnt_q,   fall_cnt_d;
    logic [PIPE_W-1:0] pipe_cnt_q,   pipe_cnt_d;
    logic [SP_W-1:0]   sp_cnt_q,     sp_cnt_d;
    logic [ROW_W-1:0]  bird_row_q,   bird_row_d;
    logic [7:0]        lfsr_q,       lfsr_d;
    logic [ROW_W-1:0]  gap_row_q,    gap_row_d;
    logic              pipe_shift_q, pipe_shift_d;
    logic              pipe_load_q,  pipe_load_d;
    logic              clear_fld_q,  clear_fld_d;
    bcd2_t             high_score_q, high_score_d;

    logic  tick_c;
    logic  fall_due_c;
    logic  score_clr_c;
    logic  score_inc_c;
    bcd2_t score_val;

    bcd2_counter u_score (
        .clk     (clk),
        .reset   (reset),
        .clear_i (score_clr_c),
        .inc_i   (score_inc_c),
        .value_o (score_val)
    );

    // Next-state, motion and pulse generation
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        fall_cnt_d   = fall_cnt_q;
        pipe_cnt_d   = pipe_cnt_q;
        sp_cnt_d     = sp_cnt_q;
        bird_row_d   = bird_row_q;
        lfsr_d       = lfsr_next(lfsr_q);
        gap_row_d    = gap_row_q;
        pipe_shift_d = 1'b0;
        pipe_load_d  = 1'b0;
        clear_fld_d  = 1'b0;
        high_score_d = high_score_q;
        tick_c       = 1'b0;
        fall_due_c   = 1'b0;
        score_clr_c  = 1'b0;
        score_inc_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                fall_cnt_d = '0;
                pipe_cnt_d = '0;
                sp_cnt_d   = '0;
                bird_row_d = START_ROW_V;
                if (flap_i) begin
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                if (collide_i) begin
                    // Collision freezes everything; score is final here
                    state_d = S_OVER;
                    if (score_val > high_score_q) begin
                        high_score_d = score_val;
                    end
                end else begin
                    tick_c     = (tick_cnt_q == TICK_LAST);
                    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);

                    if (tick_c) begin
                        if (fall_cnt_q == FALL_LAST) begin
                            fall_cnt_d = '0;
                            fall_due_c = 1'b1;
                        end else begin
                            fall_cnt_d = fall_cnt_q + FALL_W'(1);
                        end

                        if (pipe_cnt_q == PIPE_LAST) begin
                            pipe_cnt_d   = '0;
                            pipe_shift_d = 1'b1;
                            if (sp_cnt_q == SP_LAST) begin
                                sp_cnt_d    = '0;
                                pipe_load_d = 1'b1;
                                gap_row_d   = GAP_BASE_V + ROW_W'(lfsr_q[2:0]);
                            end else begin
                                sp_cnt_d = sp_cnt_q + SP_W'(1);
                            end
                        end else begin
                            pipe_cnt_d = pipe_cnt_q + PIPE_W'(1);
                        end
                    end

                    // A flap overrides a fall due in the same cycle
                    if (flap_i) begin
                        bird_row_d = (bird_row_q >= FLAP_V) ? bird_row_q - FLAP_V : '0;
                        fall_cnt_d = '0;
                    end else if (fall_due_c && (bird_row_q != MAX_ROW)) begin
                        bird_row_d = bird_row_q + ROW_W'(1);
                    end

                    score_inc_c = add_point_i;
                end
            end

            S_OVER: begin
                if (flap_i) begin
                    state_d     = S_CLEAR;
                    clear_fld_d = 1'b1;
                end
            end

            S_CLEAR: begin
                score_clr_c = 1'b1;
                bird_row_d  = START_ROW_V;
                tick_cnt_d  = '0;
                fall_cnt_d  = '0;
                pipe_cnt_d  = '0;
                sp_cnt_d    = '0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            fall_cnt_q   <= '0;
            pipe_cnt_q   <= '0;
            sp_cnt_q     <= '0;
            bird_row_q   <= START_ROW_V;
            lfsr_q       <= LFSR_SEED;
            gap_row_q    <= '0;
            pipe_shift_q <= 1'b0;
            pipe_load_q  <= 1'b0;
            clear_fld_q  <= 1'b0;
            high_score_q <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            fall_cnt_q   <= fall_cnt_d;
            pipe_cnt_q   <= pipe_cnt_d;
            sp_cnt_q     <= sp_cnt_d;
            bird_row_q   <= bird_row_d;
            lfsr_q       <= lfsr_d;
            gap_row_q    <= gap_row_d;
            pipe_shift_q <= pipe_shift_d;
            pipe_load_q  <= pipe_load_d;
            clear_fld_q  <= clear_fld_d;
            high_score_q <= high_score_d;
        end
    end

    assign state_o       = state_q;
    assign playing_o     = (state_q == S_PLAY);
    assign bird_row_o    = bird_row_q;
    assign pipe_shift_o  = pipe_shift_q;
    assign pipe_load_o   = pipe_load_q;
    assign gap_row_o     = gap_row_q;
    assign clear_field_o = clear_fld_q;
    assign score_o       = score_val;
    assign high_score_o  = high_score_q;

endmodule
